// File: rtl/serial_frame_deserializer_pkg.sv
// Shared types and constants for the serial frame deserializer: FSM encoding,
// default field widths and the counter-width helper.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PORT = 2'd1,
    LEN  = 2'd2,
    DATA = 2'd3
  } frame_state_e;

  localparam int DEF_PORT_W = 2;
  localparam int DEF_LEN_W  = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // The bit counter is shared by all three phases, so it must reach the
  // largest terminal value of any of them (and hold the value 1 loaded in IDLE).
  function automatic int cnt_width(input int port_w, input int len_w);
    int w;
    w = clog2(2 ** len_w);
    if (clog2(port_w) > w) w = clog2(port_w);
    if (clog2(len_w) > w) w = clog2(len_w);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/serial_frame_deserializer_if.sv
// Serial input stream plus valid/ack word output of the frame deserializer.
interface serial_frame_deserializer_if
  import serial_frame_pkg::*;
#(
  parameter int PORT_W = DEF_PORT_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int DATA_W = 2 ** LEN_W
);
  logic              sd;
  logic              sd_valid;
  logic              word_ack;
  logic              word_valid;
  logic [PORT_W-1:0] word_port;
  logic [LEN_W-1:0]  word_len;
  logic [DATA_W-1:0] word_data;
  logic              abort_pulse;
  logic              overflow_pulse;

  modport master (
    output sd, sd_valid, word_ack,
    input  word_valid, word_port, word_len, word_data, abort_pulse, overflow_pulse
  );

  modport slave (
    input  sd, sd_valid, word_ack,
    output word_valid, word_port, word_len, word_data, abort_pulse, overflow_pulse
  );
endinterface

// File: rtl/serial_frame_deserializer_bit_counter.sv
// Loadable up-counter with clear and a terminal-value compare, reused for the
// port, length and data phases of a frame.
module frame_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] term_val,
  output logic [W-1:0] cnt,
  output logic         at_term
);

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (load) cnt <= load_val;
    else if (inc)  cnt <= cnt + 1'b1;
  end

  assign at_term = (cnt == term_val);

endmodule

// File: rtl/serial_frame_deserializer.sv
// Deserializes port/length/payload frames from a serial stream into a
// valid/ack holding register, flagging aborted and dropped frames.
module serial_frame_deserializer
  import serial_frame_pkg::*;
#(
  parameter int PORT_W = DEF_PORT_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int DATA_W = 2 ** LEN_W
) (
  input logic                      clk,
  input logic                      rst,
  serial_frame_deserializer_if.slave bus
);

  localparam int CNT_W = cnt_width(PORT_W, LEN_W);

  frame_state_e      state, state_d;
  logic              cnt_clr, cnt_load, cnt_inc, at_term;
  logic [CNT_W-1:0]  cnt, term_val;
  logic              shift_port, shift_len, shift_data, clr_data;
  logic              frame_done, abort;

  logic [PORT_W-1:0] port_sr_p0;
  logic [LEN_W-1:0]  len_sr_p0;
  logic [DATA_W-1:0] data_sr_p0, data_shift;

  logic              vld_p1, abort_p1, ovf_p1;
  logic [PORT_W-1:0] port_p1;
  logic [LEN_W-1:0]  len_p1;
  logic [DATA_W-1:0] data_p1;

  frame_bit_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (CNT_W'(1)),
    .inc      (cnt_inc),
    .term_val (term_val),
    .cnt      (cnt),
    .at_term  (at_term)
  );

  // Payload including the bit arriving this cycle; the completion path
  // loads this so the last bit needs no extra cycle.
  assign data_shift = DATA_W'({data_sr_p0, bus.sd});

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d    = state;
    cnt_clr    = 1'b0;
    cnt_load   = 1'b0;
    cnt_inc    = 1'b0;
    term_val   = '0;
    shift_port = 1'b0;
    shift_len  = 1'b0;
    shift_data = 1'b0;
    clr_data   = 1'b0;
    frame_done = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.sd_valid) begin
          shift_port = 1'b1;
          if (PORT_W == 1) begin
            state_d = LEN;
            cnt_clr = 1'b1;
          end else begin
            state_d  = PORT;
            cnt_load = 1'b1;
          end
        end
      end
      PORT: begin
        term_val = CNT_W'(PORT_W - 1);
        if (!bus.sd_valid) begin
          abort   = 1'b1;
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else begin
          shift_port = 1'b1;
          if (at_term) begin
            state_d = LEN;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      LEN: begin
        term_val = CNT_W'(LEN_W - 1);
        if (!bus.sd_valid) begin
          abort   = 1'b1;
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else begin
          shift_len = 1'b1;
          if (at_term) begin
            state_d  = DATA;
            cnt_clr  = 1'b1;
            clr_data = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      DATA: begin
        term_val = CNT_W'(len_sr_p0);
        if (!bus.sd_valid) begin
          abort   = 1'b1;
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else begin
          shift_data = 1'b1;
          if (at_term) begin
            frame_done = 1'b1;
            state_d    = IDLE;
            cnt_clr    = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: field shift registers
  always_ff @(posedge clk) begin
    if (rst) begin
      port_sr_p0 <= '0;
      len_sr_p0  <= '0;
      data_sr_p0 <= '0;
    end else begin
      if (shift_port) port_sr_p0 <= PORT_W'({port_sr_p0, bus.sd});
      if (shift_len)  len_sr_p0  <= LEN_W'({len_sr_p0, bus.sd});
      if (clr_data)        data_sr_p0 <= '0;
      else if (shift_data) data_sr_p0 <= data_shift;
    end
  end

  // Stage p1: holding register and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      abort_p1 <= 1'b0;
      ovf_p1   <= 1'b0;
      port_p1  <= '0;
      len_p1   <= '0;
      data_p1  <= '0;
    end else begin
      abort_p1 <= abort;
      ovf_p1   <= frame_done && vld_p1 && !bus.word_ack;
      if (frame_done && (!vld_p1 || bus.word_ack)) begin
        vld_p1  <= 1'b1;
        port_p1 <= port_sr_p0;
        len_p1  <= len_sr_p0;
        data_p1 <= data_shift;
      end else if (vld_p1 && bus.word_ack) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.word_valid     = vld_p1;
  assign bus.word_port      = port_p1;
  assign bus.word_len       = len_p1;
  assign bus.word_data      = data_p1;
  assign bus.abort_pulse    = abort_p1;
  assign bus.overflow_pulse = ovf_p1;

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Self-checking bench for serial_frame_deserializer: directed table, corner
// sequences, and a randomized stream against a frame-level reference model.
module tb_serial_frame_deserializer;

  localparam int PORT_W = 2;
  localparam int LEN_W  = 4;
  localparam int DATA_W = 16;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  serial_frame_deserializer_if #(.PORT_W(PORT_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) bus();

  serial_frame_deserializer #(.PORT_W(PORT_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [PORT_W-1:0] port;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] exp_data;
  } vec_t;

  typedef struct {
    bit                sd;
    bit                v;
    bit                done;
    bit                abrt;
    logic [PORT_W-1:0] p;
    logic [LEN_W-1:0]  l;
    logic [DATA_W-1:0] d;
  } cyc_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic v, input logic [PORT_W-1:0] p,
                            input logic [LEN_W-1:0] l, input logic [DATA_W-1:0] d);
    check({tag, ".valid"}, 32'(bus.word_valid), 32'(v));
    check({tag, ".port"},  32'(bus.word_port),  32'(p));
    check({tag, ".len"},   32'(bus.word_len),   32'(l));
    check({tag, ".data"},  32'(bus.word_data),  32'(d));
  endtask

  function automatic logic frame_bit(input logic [PORT_W-1:0] p, input logic [LEN_W-1:0] l,
                                     input logic [DATA_W-1:0] d, input int i);
    if (i < PORT_W) return p[PORT_W-1-i];
    if (i < PORT_W + LEN_W) return l[LEN_W-1-(i-PORT_W)];
    return d[int'(l) - (i - PORT_W - LEN_W)];
  endfunction

  // Sends the first nsend bits of a frame; ack_last raises word_ack on the final bit.
  task automatic drive_frame(input logic [PORT_W-1:0] p, input logic [LEN_W-1:0] l,
                             input logic [DATA_W-1:0] d, input int nsend, input bit ack_last);
    int total;
    total = PORT_W + LEN_W + int'(l) + 1;
    for (int i = 0; i < nsend; i++) begin
      bus.sd       = frame_bit(p, l, d, i);
      bus.sd_valid = 1'b1;
      bus.word_ack = ack_last && (i == total - 1);
      step();
    end
    bus.sd       = 1'b0;
    bus.sd_valid = 1'b0;
    bus.word_ack = 1'b0;
  endtask

  task automatic ack_word();
    bus.word_ack = 1'b1;
    step();
    bus.word_ack = 1'b0;
  endtask

  vec_t vecs[6];
  cyc_t cq[$];

  initial begin
    cyc_t              c;
    bit                pend_abort;
    bit                ack;
    int                gap, total, nsend;
    logic [PORT_W-1:0] p, ep;
    logic [LEN_W-1:0]  l, el;
    logic [DATA_W-1:0] d, ed, mask;
    logic              ev, e_abort, e_ovf;

    vecs[0] = '{port: 2'd2, len: 4'd3,  data: 16'h000B, exp_data: 16'h000B};
    vecs[1] = '{port: 2'd1, len: 4'd15, data: 16'hA5C3, exp_data: 16'hA5C3};
    vecs[2] = '{port: 2'd3, len: 4'd0,  data: 16'h0001, exp_data: 16'h0001};
    vecs[3] = '{port: 2'd0, len: 4'd1,  data: 16'h0002, exp_data: 16'h0002};
    vecs[4] = '{port: 2'd2, len: 4'd7,  data: 16'hFF5A, exp_data: 16'h005A};
    vecs[5] = '{port: 2'd3, len: 4'd0,  data: 16'h0000, exp_data: 16'h0000};

    bus.sd = 1'b0; bus.sd_valid = 1'b0; bus.word_ack = 1'b0;
    rst = 1'b1;
    step(); step();
    check_word("reset", 1'b0, '0, '0, '0);
    check("reset.abort", 32'(bus.abort_pulse), 32'd0);
    check("reset.ovf", 32'(bus.overflow_pulse), 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      drive_frame(vecs[i].port, vecs[i].len, vecs[i].data, PORT_W + LEN_W + int'(vecs[i].len) + 1, 1'b0);
      check_word($sformatf("vec%0d", i), 1'b1, vecs[i].port, vecs[i].len, vecs[i].exp_data);
      check($sformatf("vec%0d.ovf", i), 32'(bus.overflow_pulse), 32'd0);
      ack_word();
      check_word($sformatf("vec%0d.acked", i), 1'b0, vecs[i].port, vecs[i].len, vecs[i].exp_data);
      step();
    end

    // Abort mid-data while a word is held
    drive_frame(2'd1, 4'd2, 16'h0005, PORT_W + LEN_W + 3, 1'b0);
    check_word("abort.pre", 1'b1, 2'd1, 4'd2, 16'h0005);
    drive_frame(2'd2, 4'd7, 16'h0055, PORT_W + LEN_W + 3, 1'b0);
    step();
    check("abort.pulse", 32'(bus.abort_pulse), 32'd1);
    check_word("abort.held", 1'b1, 2'd1, 4'd2, 16'h0005);
    step();
    check("abort.pulse_end", 32'(bus.abort_pulse), 32'd0);
    ack_word();
    drive_frame(2'd3, 4'd0, 16'h0001, PORT_W + LEN_W + 1, 1'b0);
    check_word("abort.next", 1'b1, 2'd3, 4'd0, 16'h0001);
    check("abort.next_pulse", 32'(bus.abort_pulse), 32'd0);
    ack_word();
    step();

    // Overflow: back-to-back frames without ack
    drive_frame(2'd1, 4'd3, 16'h0009, PORT_W + LEN_W + 4, 1'b0);
    check_word("ovf.first", 1'b1, 2'd1, 4'd3, 16'h0009);
    drive_frame(2'd2, 4'd2, 16'h0006, PORT_W + LEN_W + 3, 1'b0);
    check("ovf.pulse", 32'(bus.overflow_pulse), 32'd1);
    check_word("ovf.kept", 1'b1, 2'd1, 4'd3, 16'h0009);
    step();
    check("ovf.pulse_end", 32'(bus.overflow_pulse), 32'd0);
    ack_word();
    check("ovf.acked", 32'(bus.word_valid), 32'd0);

    // Ack coinciding with completion of the second frame
    drive_frame(2'd3, 4'd1, 16'h0003, PORT_W + LEN_W + 2, 1'b0);
    check_word("race.first", 1'b1, 2'd3, 4'd1, 16'h0003);
    drive_frame(2'd0, 4'd4, 16'h001D, PORT_W + LEN_W + 5, 1'b1);
    check_word("race.second", 1'b1, 2'd0, 4'd4, 16'h001D);
    check("race.ovf", 32'(bus.overflow_pulse), 32'd0);
    ack_word();
    step();

    // Reset during the length phase
    drive_frame(2'd2, 4'd5, 16'h002A, PORT_W + LEN_W + 6, 1'b0);
    check_word("rstmid.pre", 1'b1, 2'd2, 4'd5, 16'h002A);
    drive_frame(2'd3, 4'd9, 16'h0155, PORT_W + 2, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_word("rstmid.clear", 1'b0, '0, '0, '0);
    check("rstmid.abort", 32'(bus.abort_pulse), 32'd0);
    step();
    check("rstmid.no_abort", 32'(bus.abort_pulse), 32'd0);
    drive_frame(2'd0, 4'd1, 16'h0002, PORT_W + LEN_W + 2, 1'b0);
    check_word("rstmid.next", 1'b1, 2'd0, 4'd1, 16'h0002);

    // Randomized stream against the frame-level model
    rst = 1'b1;
    step();
    rst = 1'b0;
    pend_abort = 1'b0;
    for (int f = 0; f < 120; f++) begin
      gap = $urandom_range(0, 2);
      if (pend_abort && gap == 0) gap = 1;
      for (int g = 0; g < gap; g++) begin
        c = '{sd: 1'b0, v: 1'b0, done: 1'b0, abrt: 1'b0, p: '0, l: '0, d: '0};
        c.sd   = 1'($urandom_range(0, 1));
        c.abrt = pend_abort && (g == 0);
        cq.push_back(c);
      end
      p     = PORT_W'($urandom);
      l     = LEN_W'($urandom);
      mask  = {DATA_W{1'b1}} >> (DATA_W - 1 - int'(l));
      d     = DATA_W'($urandom) & mask;
      total = PORT_W + LEN_W + int'(l) + 1;
      nsend = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, total - 1)) : total;
      for (int i = 0; i < nsend; i++) begin
        c = '{sd: 1'b0, v: 1'b1, done: 1'b0, abrt: 1'b0, p: p, l: l, d: d};
        c.sd   = frame_bit(p, l, d, i);
        c.done = (i == total - 1);
        cq.push_back(c);
      end
      pend_abort = (nsend < total);
    end
    for (int g = 0; g < 3; g++) begin
      c = '{sd: 1'b0, v: 1'b0, done: 1'b0, abrt: 1'b0, p: '0, l: '0, d: '0};
      c.abrt = pend_abort && (g == 0);
      cq.push_back(c);
    end

    ev = 1'b0; ep = '0; el = '0; ed = '0;
    for (int k = 0; k < cq.size(); k++) begin
      ack = ($urandom_range(0, 2) == 0);
      bus.sd       = cq[k].sd;
      bus.sd_valid = cq[k].v;
      bus.word_ack = ack;
      step();
      e_abort = cq[k].abrt;
      e_ovf   = 1'b0;
      if (cq[k].done) begin
        if (!ev || ack) begin
          ev = 1'b1; ep = cq[k].p; el = cq[k].l; ed = cq[k].d;
        end else begin
          e_ovf = 1'b1;
        end
      end else if (ev && ack) begin
        ev = 1'b0;
      end
      check($sformatf("rand.cyc%0d {vld,abt,ovf,port,len,data}", k),
            32'({bus.word_valid, bus.abort_pulse, bus.overflow_pulse, bus.word_port, bus.word_len, bus.word_data}),
            32'({ev, e_abort, e_ovf, ep, el, ed}));
    end
    bus.sd_valid = 1'b0;
    bus.word_ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_deserializer.md
Name: serial_frame_deserializer

Overview:
Downstream consumer of the serial transmitter's output stream. It takes the transmitted frame (port field, length field, payload) and extracts the port number, the length and the right-justified payload word. It presents them through a valid/ack holding register to the parallel side of the design. It flags frames that are aborted mid-stream and frames dropped because the holding register was still full.

Parameters:
PORT_W, 2, width of port field; legal range >= 1.
LEN_W, 4, width of length field; payload bit count = len+1.
DATA_W, 2**LEN_W (16), payload register width; must be >= 2**LEN_W.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
sd  input  1  serial data from transmitter, MSB-first per field
sd_valid  input  1  high for every cycle that sd carries a frame bit; contiguous within a frame
word_ack  input  1  consumer accepts current word (meaningful only while word_valid=1)
word_valid  output  1  holding register contains an unconsumed word
word_port  output  PORT_W  port field of held frame
word_len  output  LEN_W  length field of held frame
word_data  output  DATA_W  payload, right-justified, upper bits zero
abort_pulse  output  1  one-cycle pulse: sd_valid dropped mid-frame
overflow_pulse  output  1  one-cycle pulse: completed frame dropped (holding register full)

Behaviour:
- Reset (sync, rst=1 at posedge): FSM=IDLE; counter, shift registers and all outputs = 0. Reset mid-frame discards the partial frame with no pulse.
- Frame format: PORT_W port bits, then LEN_W length bits, then len+1 data bits. All fields MSB-first. Each bit is sampled on a posedge with sd_valid=1.
- FSM states: IDLE, PORT, LEN, DATA.
- IDLE: on sd_valid=1, shift sd into port_sr, cnt=1. Next state is PORT, or LEN with cnt=0 if PORT_W==1.
- PORT: on sd_valid=1, shift into port_sr. At cnt==PORT_W-1: go LEN, cnt=0. Otherwise cnt++.
- LEN: on sd_valid=1, shift into len_sr. At cnt==LEN_W-1: go DATA, cnt=0, data_sr cleared.
- DATA: on sd_valid=1, data_sr = {data_sr[DATA_W-2:0], sd}. At cnt==len_sr: frame complete, go IDLE. Otherwise cnt++.
- Abort: in PORT/LEN/DATA with sd_valid=0, assert abort_pulse next cycle, go IDLE, discard the frame. The holding register is unaffected.
- Completion, holding-register update at the same posedge as the final data bit:
  - If word_valid=0, or word_valid=1 with word_ack=1: load port/len/data and set word_valid=1. word_valid is visible the cycle after the final bit (latency 1).
  - If word_valid=1 with word_ack=0: keep the old word and pulse overflow_pulse for 1 cycle.
- Ack: word_ack=1 with word_valid=1 and no simultaneous completion clears word_valid next cycle. Data outputs keep their last value. word_ack while word_valid=0 is ignored.
- Back-to-back: sd_valid held high after a final data bit is taken as the first port bit of the next frame (IDLE accepts it). No gap cycle is required.
- Minimum frame is PORT_W+LEN_W+1 bits; maximum is PORT_W+LEN_W+2**LEN_W bits. No other error cases exist.
- Outputs word_* and pulses are registered. No combinational path exists from inputs to outputs.

Decomposition:
- Package serial_frame_pkg holds:
  - FSM state encoding (IDLE=2'd0, PORT=2'd1, LEN=2'd2, DATA=2'd3).
  - Default PORT_W/LEN_W constants.
  - Counter width function clog2(2**LEN_W).
- One sub-module, frame_bit_counter: loadable up-counter with clear and terminal-compare input, reused across the PORT/LEN/DATA phases.

Test Plan:
- Basic frame: port=10, len=0011, data=1011 (10 bits contiguous) -> 1 cycle after 10th bit, word_valid=1, word_port=2, word_len=3, word_data=16'h000B.
- Max length: port=01, len=1111, 16 data bits 0xA5C3 -> word_data=16'hA5C3, word_len=15; pulse word_ack -> word_valid=0 next cycle.
- Abort: sd_valid low after 3rd data bit of a len=7 frame -> abort_pulse=1 for one cycle, word_valid unchanged; next full frame (port=11, len=0, data=1) gives word_data=16'h0001.
- Overflow/ack race: two back-to-back frames with word_ack=0 -> first word held, overflow_pulse on second. Repeat with word_ack=1 on the second frame's completion cycle -> second word loaded, word_valid stays 1, no overflow.
- Reset mid-frame: rst=1 during LEN phase -> all outputs 0, FSM IDLE. The following frame (port=00, len=1, data=10) decodes to word_data=16'h0002 with no stale bits.
